// File: rtl/cache_ahb_burst_rd.sv
// AHB-Lite read master: fills one cache line per request with a single WRAPn or INCRn burst,
// streaming each returned word with its line index and aborting on an ERROR response.
module cache_ahb_burst_rd #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter bit          WRAP_EN    = 1'b1
) (
  input  logic                          i_hclk,
  input  logic                          i_hreset,
  input  logic                          i_req,
  input  logic [ADDR_W-3:0]             i_addr,
  output logic                          o_busy,
  output logic                          o_rvalid,
  output logic [31:0]                   o_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] o_rindex,
  output logic                          o_done,
  output logic                          o_err,
  output logic                          o_hsel,
  output logic [ADDR_W-1:0]             o_haddr,
  output logic                          o_hwrite,
  output logic [2:0]                    o_hsize,
  output logic [2:0]                    o_hburst,
  output logic [3:0]                    o_hprot,
  output logic [1:0]                    o_htrans,
  output logic                          o_hmastlock,
  output logic                          o_hready,
  output logic [31:0]                   o_hwdata,
  input  logic                          i_hready,
  input  logic                          i_hresp,
  input  logic [31:0]                   i_hrdata
);

  localparam int unsigned IW = $clog2(LINE_WORDS);
  localparam logic [IW:0]   AcntFull = (IW+1)'(LINE_WORDS);
  localparam logic [IW-1:0] DcntLast = IW'(LINE_WORDS - 1);
  localparam logic [2:0]    HburstLen = (IW == 2) ? 3'b010 : (IW == 3) ? 3'b100 : 3'b110;

  typedef enum logic [1:0] {StIdle, StBurst, StErr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [IW:0]       acnt_q, acnt_d;
  logic [IW-1:0]     dcnt_q, dcnt_d;
  logic              dpend_q, dpend_d;

  logic [IW-1:0] start, aoff, doff;
  logic          addr_act, beat, beat_err, last_beat;

  // Offsets are IW bits wide so the sum truncates, wrapping inside the line.
  assign start     = WRAP_EN ? addr_q[IW-1:0] : '0;
  assign aoff      = start + acnt_q[IW-1:0];
  assign doff      = start + dcnt_q;
  assign addr_act  = (state_q == StBurst) && (acnt_q < AcntFull);
  assign beat      = (state_q == StBurst) && dpend_q && i_hready && !i_hresp;
  assign beat_err  = (state_q == StBurst) && dpend_q && i_hresp;
  assign last_beat = beat && (dcnt_q == DcntLast);

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      acnt_q  <= '0;
      dcnt_q  <= '0;
      dpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acnt_q  <= acnt_d;
      dcnt_q  <= dcnt_d;
      dpend_q <= dpend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acnt_d  = acnt_q;
    dcnt_d  = dcnt_q;
    dpend_d = dpend_q;
    unique case (state_q)
      StIdle: begin
        if (i_req) begin
          addr_d  = i_addr;
          acnt_d  = '0;
          dcnt_d  = '0;
          dpend_d = 1'b0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (beat_err) begin
          state_d = StErr;
        end else begin
          // A ready cycle retires the current data phase and accepts the pending address.
          if (i_hready) begin
            dpend_d = addr_act;
            if (addr_act) acnt_d = acnt_q + 1'b1;
          end
          if (beat) dcnt_d = dcnt_q + 1'b1;
          if (last_beat) state_d = StIdle;
        end
      end
      StErr: begin
        if (i_hready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_hsel   = 1'b0;
    o_htrans = 2'b00;
    o_haddr  = '0;
    o_rvalid = 1'b0;
    o_rdata  = '0;
    o_rindex = '0;
    o_done   = 1'b0;
    o_err    = 1'b0;
    unique case (state_q)
      StBurst: begin
        o_hsel  = addr_act || dpend_q;
        o_haddr = {addr_q[ADDR_W-3:IW], aoff, 2'b00};
        if (addr_act && !beat_err) o_htrans = (acnt_q == '0) ? 2'b10 : 2'b11;
        if (beat) begin
          o_rvalid = 1'b1;
          o_rdata  = i_hrdata;
          o_rindex = doff;
        end
        o_done = last_beat;
      end
      StErr: begin
        o_done = i_hready;
        o_err  = i_hready;
      end
      default: ;
    endcase
  end

  assign o_busy      = (state_q != StIdle);
  assign o_hwrite    = 1'b0;
  assign o_hsize     = 3'h2;
  assign o_hburst    = HburstLen | {2'b00, ~WRAP_EN};
  assign o_hprot     = 4'h1;
  assign o_hmastlock = 1'b0;
  assign o_hready    = i_hready;
  assign o_hwdata    = '0;

endmodule

// File: tb/tb_cache_ahb_burst_rd.sv
// Scoreboard bench: WRAP4 and INCR8 instances share one AHB slave model driven by a ready script.
module tb_cache_ahb_burst_rd;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        hready, hresp;
  logic        a_req, b_req;
  logic [29:0] a_addr, b_addr;

  logic        a_busy, a_rvalid, a_done, a_err, a_hsel, a_hwrite, a_hmastlock, a_hready;
  logic [31:0] a_rdata, a_haddr, a_hwdata, a_hrdata;
  logic [1:0]  a_rindex, a_htrans;
  logic [2:0]  a_hsize, a_hburst;
  logic [3:0]  a_hprot;

  logic        b_busy, b_rvalid, b_done, b_err, b_hsel, b_hwrite, b_hmastlock, b_hready;
  logic [31:0] b_rdata, b_haddr, b_hwdata, b_hrdata;
  logic [2:0]  b_rindex;
  logic [1:0]  b_htrans;
  logic [2:0]  b_hsize, b_hburst;
  logic [3:0]  b_hprot;

  cache_ahb_burst_rd #(.ADDR_W(32), .LINE_WORDS(4), .WRAP_EN(1'b1)) u_dut_a (
    .i_hclk(clk), .i_hreset(rst), .i_req(a_req), .i_addr(a_addr), .o_busy(a_busy),
    .o_rvalid(a_rvalid), .o_rdata(a_rdata), .o_rindex(a_rindex), .o_done(a_done), .o_err(a_err),
    .o_hsel(a_hsel), .o_haddr(a_haddr), .o_hwrite(a_hwrite), .o_hsize(a_hsize),
    .o_hburst(a_hburst), .o_hprot(a_hprot), .o_htrans(a_htrans), .o_hmastlock(a_hmastlock),
    .o_hready(a_hready), .o_hwdata(a_hwdata), .i_hready(hready), .i_hresp(hresp),
    .i_hrdata(a_hrdata)
  );

  cache_ahb_burst_rd #(.ADDR_W(32), .LINE_WORDS(8), .WRAP_EN(1'b0)) u_dut_b (
    .i_hclk(clk), .i_hreset(rst), .i_req(b_req), .i_addr(b_addr), .o_busy(b_busy),
    .o_rvalid(b_rvalid), .o_rdata(b_rdata), .o_rindex(b_rindex), .o_done(b_done), .o_err(b_err),
    .o_hsel(b_hsel), .o_haddr(b_haddr), .o_hwrite(b_hwrite), .o_hsize(b_hsize),
    .o_hburst(b_hburst), .o_hprot(b_hprot), .o_htrans(b_htrans), .o_hmastlock(b_hmastlock),
    .o_hready(b_hready), .o_hwdata(b_hwdata), .i_hready(hready), .i_hresp(hresp),
    .i_hrdata(b_hrdata)
  );

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'h5A00_0000 | a;
  endfunction

  // Slave: data phase returns a word derived from the address it accepted.
  logic        a_dv, a_dv_n, b_dv, b_dv_n;
  logic [31:0] a_da, a_da_n, b_da, b_da_n;
  always @(negedge clk) begin
    if (rst) begin
      a_dv_n = 1'b0;
      b_dv_n = 1'b0;
    end else if (hready) begin
      a_dv_n = a_htrans[1];
      a_da_n = a_haddr;
      b_dv_n = b_htrans[1];
      b_da_n = b_haddr;
    end
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dv <= 1'b0;
      b_dv <= 1'b0;
      a_da <= '0;
      b_da <= '0;
    end else begin
      a_dv <= a_dv_n;
      a_da <= a_da_n;
      b_dv <= b_dv_n;
      b_da <= b_da_n;
    end
  end
  assign a_hrdata = a_dv ? dat(a_da) : 32'h0BAD_F00D;
  assign b_hrdata = b_dv ? dat(b_da) : 32'h0BAD_F00D;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected beat: {rvalid, done, err, index(4), data(32)}; address phase: {htrans, haddr}.
  logic [38:0] rq_a[$], rq_b[$];
  logic [33:0] aq_a[$], aq_b[$];
  logic [1:0]  scr[$];

  function automatic logic [38:0] bt(input bit v, input bit d, input bit e, input int idx,
                                     input logic [31:0] data);
    return {v, d, e, 4'(idx), data};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (a_rvalid || a_done) begin
        if (rq_a.size() == 0) chk("a_unexpected_beat", {a_rvalid, a_done, a_err}, 0);
        else chk("a_beat", {a_rvalid, a_done, a_err, 2'b00, a_rvalid ? a_rindex : 2'b00, a_rdata},
                 rq_a.pop_front());
      end else chk("a_rdata_idle", {a_err, a_rdata}, 0);
      if (a_htrans != 2'b00) begin
        chk("a_hsel", a_hsel, 1);
        if (aq_a.size() == 0) chk("a_unexpected_addr", {a_htrans, a_haddr}, 0);
        else begin
          chk("a_addr", {a_htrans, a_haddr}, aq_a[0]);
          if (hready) void'(aq_a.pop_front());
        end
      end
      if (b_rvalid || b_done) begin
        if (rq_b.size() == 0) chk("b_unexpected_beat", {b_rvalid, b_done, b_err}, 0);
        else chk("b_beat", {b_rvalid, b_done, b_err, 1'b0, b_rvalid ? b_rindex : 3'b000, b_rdata},
                 rq_b.pop_front());
      end else chk("b_rdata_idle", {b_err, b_rdata}, 0);
      if (b_htrans != 2'b00) begin
        if (aq_b.size() == 0) chk("b_unexpected_addr", {b_htrans, b_haddr}, 0);
        else begin
          chk("b_addr", {b_htrans, b_haddr}, aq_b[0]);
          if (hready) void'(aq_b.pop_front());
        end
      end
    end
  end

  task automatic apply_scr();
    if (scr.size() != 0) {hready, hresp} = scr.pop_front();
    else {hready, hresp} = 2'b10;
  endtask

  // Cycle 0 presents the request; counts cycles until o_done.
  task automatic fill(input bit sel_b, input logic [29:0] addr, input int exp_cyc,
                      input string nm);
    int c;
    bit dn;
    @(posedge clk); #1;
    if (sel_b) begin b_req = 1'b1; b_addr = addr; end
    else begin a_req = 1'b1; a_addr = addr; end
    @(posedge clk); #1;
    a_req = 1'b0;
    b_req = 1'b0;
    c = 1;
    apply_scr();
    dn = 1'b0;
    while (!dn && c < 100) begin
      @(negedge clk);
      dn = sel_b ? b_done : a_done;
      if (!dn) begin
        @(posedge clk); #1;
        c++;
        apply_scr();
      end
    end
    chk({nm, "_cycles"}, c, exp_cyc);
    @(posedge clk); #1;
    hready = 1'b1;
    hresp  = 1'b0;
    scr.delete();
    @(negedge clk);
    chk({nm, "_idle_after"}, sel_b ? {b_busy, b_htrans} : {a_busy, a_htrans}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc[$];
    rst = 1'b1;
    hready = 1'b1;
    hresp = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    a_addr = '0;
    b_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {a_busy, a_hsel, a_rvalid, a_done, a_err, a_htrans, a_rdata}, 0);
    chk("rst_consts", {a_hwrite, a_hsize, a_hprot, a_hmastlock, a_hwdata},
        {1'b0, 3'h2, 4'h1, 1'b0, 32'h0});
    chk("a_hburst", a_hburst, 3'b010);
    chk("b_hburst", b_hburst, 3'b101);
    hready = 1'b0;
    #1 chk("hready_pass_lo", {a_hready, b_hready}, 2'b00);
    hready = 1'b1;
    #1 chk("hready_pass_hi", {a_hready, b_hready}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b0;

    // WRAP4 from word 2 of line 0x1000.
    aq_a.push_back({2'b10, 32'h1008});
    aq_a.push_back({2'b11, 32'h100C});
    aq_a.push_back({2'b11, 32'h1000});
    aq_a.push_back({2'b11, 32'h1004});
    rq_a.push_back(bt(1, 0, 0, 2, dat(32'h1008)));
    rq_a.push_back(bt(1, 0, 0, 3, dat(32'h100C)));
    rq_a.push_back(bt(1, 0, 0, 0, dat(32'h1000)));
    rq_a.push_back(bt(1, 1, 0, 1, dat(32'h1004)));
    fill(1'b0, 30'h402, 5, "wrap4");

    // INCR8 from the line base 0x2020.
    for (int i = 0; i < 8; i++) begin
      aq_b.push_back({(i == 0) ? 2'b10 : 2'b11, 32'h2020 + 32'(4 * i)});
      rq_b.push_back(bt(1, i == 7, 0, i, dat(32'h2020 + 32'(4 * i))));
    end
    fill(1'b1, 30'h80D, 9, "incr8");

    // Two waits on data beat 1, one on the address phase of beat 3.
    aq_a.push_back({2'b10, 32'h48CC});
    aq_a.push_back({2'b11, 32'h48C0});
    aq_a.push_back({2'b11, 32'h48C4});
    aq_a.push_back({2'b11, 32'h48C8});
    rq_a.push_back(bt(1, 0, 0, 3, dat(32'h48CC)));
    rq_a.push_back(bt(1, 0, 0, 0, dat(32'h48C0)));
    rq_a.push_back(bt(1, 0, 0, 1, dat(32'h48C4)));
    rq_a.push_back(bt(1, 1, 0, 2, dat(32'h48C8)));
    scr = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10};
    fill(1'b0, 30'h1233, 8, "waits");

    // ERROR on data beat 2: only beats 0 and 1 delivered, then done+err.
    aq_a.push_back({2'b10, 32'h0000});
    aq_a.push_back({2'b11, 32'h0004});
    aq_a.push_back({2'b11, 32'h0008});
    rq_a.push_back(bt(1, 0, 0, 0, dat(32'h0000)));
    rq_a.push_back(bt(1, 0, 0, 1, dat(32'h0004)));
    rq_a.push_back(bt(0, 1, 1, 0, 32'h0));
    scr = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
    fill(1'b0, 30'h0, 5, "error");

    // Reset after beat 1 of a WRAP fill from word 1 of line 0x410.
    aq_a.push_back({2'b10, 32'h0414});
    aq_a.push_back({2'b11, 32'h0418});
    aq_a.push_back({2'b11, 32'h041C});
    rq_a.push_back(bt(1, 0, 0, 1, dat(32'h0414)));
    rq_a.push_back(bt(1, 0, 0, 2, dat(32'h0418)));
    @(posedge clk); #1;
    a_req = 1'b1;
    a_addr = 30'h105;
    @(posedge clk); #1;
    a_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {a_busy, a_hsel, a_rvalid, a_done, a_err, a_htrans, a_rdata}, 0);
    chk("midrst_haddr", a_haddr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_drained", {16'(rq_a.size()), 16'(aq_a.size())}, 0);

    // i_req held high: second fill uses i_addr at the idle cycle, not the mid-fill value.
    aq_a.push_back({2'b10, 32'h100C});
    aq_a.push_back({2'b11, 32'h1000});
    aq_a.push_back({2'b11, 32'h1004});
    aq_a.push_back({2'b11, 32'h1008});
    rq_a.push_back(bt(1, 0, 0, 3, dat(32'h100C)));
    rq_a.push_back(bt(1, 0, 0, 0, dat(32'h1000)));
    rq_a.push_back(bt(1, 0, 0, 1, dat(32'h1004)));
    rq_a.push_back(bt(1, 1, 0, 2, dat(32'h1008)));
    aq_a.push_back({2'b10, 32'h3104});
    aq_a.push_back({2'b11, 32'h3108});
    aq_a.push_back({2'b11, 32'h310C});
    aq_a.push_back({2'b11, 32'h3100});
    rq_a.push_back(bt(1, 0, 0, 1, dat(32'h3104)));
    rq_a.push_back(bt(1, 0, 0, 2, dat(32'h3108)));
    rq_a.push_back(bt(1, 0, 0, 3, dat(32'h310C)));
    rq_a.push_back(bt(1, 1, 0, 0, dat(32'h3100)));
    @(posedge clk); #1;
    a_req = 1'b1;
    a_addr = 30'h403;
    for (int c = 0; c < 14; c++) begin
      if (c == 2) a_addr = 30'hC41;
      if (c == 8) a_req = 1'b0;
      @(negedge clk);
      if (a_done) dc.push_back(c);
      if (c == 6) chk("b2b_idle_gap", {a_busy, a_htrans}, 0);
      if (c == 7) chk("b2b_nonseq", a_htrans, 2'b10);
      @(posedge clk); #1;
    end
    chk("b2b_done_count", dc.size(), 2);
    if (dc.size() >= 1) chk("b2b_done0_cycle", dc[0], 5);
    if (dc.size() >= 2) chk("b2b_done1_cycle", dc[1], 11);

    @(negedge clk);
    chk("queues_drained",
        {16'(rq_a.size()), 16'(aq_a.size()), 16'(rq_b.size()), 16'(aq_b.size())}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
